// File: rtl/oled_i2c_arbiter_if.sv
// ---------------------------------------------------------------------------
// oled_i2c_arbiter_if
//  Bundles the requester-side and i2c_master-side signals of the OLED
//  register-write arbiter.
//  Ports (signals):
//   req, req_addr, req_data, req_wen : requester burst request / write strobe
//   grant, req_done, req_err         : per-requester grant and completion
//   i2c_reg_addr, i2c_reg_data,
//   i2c_write_en, i2c_done           : single i2c_master register-write port
//   busy                             : arbiter not idle
//  Modports: slave = arbiter side, master = requesters + i2c_master side.
// ---------------------------------------------------------------------------
interface oled_i2c_arbiter_if #(
   parameter int unsigned NUM_REQ = 3
) ();
   logic [NUM_REQ-1:0]   req;
   logic [8*NUM_REQ-1:0] req_addr;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_wen;
   logic [NUM_REQ-1:0]   grant;
   logic [NUM_REQ-1:0]   req_done;
   logic [NUM_REQ-1:0]   req_err;
   logic [7:0]           i2c_reg_addr;
   logic [7:0]           i2c_reg_data;
   logic                 i2c_write_en;
   logic                 i2c_done;
   logic                 busy;

   modport slave (
      input  req, req_addr, req_data, req_wen, i2c_done,
      output grant, req_done, req_err, i2c_reg_addr, i2c_reg_data, i2c_write_en, busy
   );

   modport master (
      output req, req_addr, req_data, req_wen, i2c_done,
      input  grant, req_done, req_err, i2c_reg_addr, i2c_reg_data, i2c_write_en, busy
   );
endinterface

// File: rtl/oled_i2c_arbiter.sv
// ---------------------------------------------------------------------------
// oled_i2c_arbiter
//  Shares the single i2c_master register-write port among NUM_REQ OLED
//  requesters (0 = init, 1 = full-screen disp, 2 = dot matrix). A requester
//  holds req high for a burst and keeps the grant for that burst; bursts are
//  served round-robin. A per-transfer watchdog aborts a hung bus transfer.
//  Ports:
//   clk    : system clock
//   reset  : asynchronous, active-high reset
//   bus    : oled_i2c_arbiter_if.slave (requester and i2c_master signals)
// ---------------------------------------------------------------------------
module oled_i2c_arbiter #(
   parameter int unsigned          NUM_REQ   = 3,
   parameter int unsigned          TO_WIDTH  = 16,
   parameter logic [TO_WIDTH-1:0]  TO_CYCLES = TO_WIDTH'(60000)
) (
   input  logic                clk,
   input  logic                reset,
   oled_i2c_arbiter_if.slave   bus
);

   localparam int unsigned          IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [NUM_REQ-1:0]   LSB_ONE = NUM_REQ'(1);
   localparam logic [TO_WIDTH-1:0]  TO_LAST = TO_CYCLES - TO_WIDTH'(1);
   localparam logic [IDX_W-1:0]     IDX_MAX = IDX_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRANT   = 2'd1,
      S_XFER    = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   state_t               state_q;
   logic [IDX_W-1:0]     idx_q;
   logic [IDX_W-1:0]     rr_ptr_q;
   logic [IDX_W-1:0]     rr_ptr_d;
   logic [TO_WIDTH-1:0]  wdog_q;
   logic [NUM_REQ-1:0]   grant_q;
   logic [NUM_REQ-1:0]   done_q;
   logic [NUM_REQ-1:0]   err_q;
   logic [7:0]           addr_q;
   logic [7:0]           data_q;
   logic                 wen_q;
   logic                 busy_q;

   logic [IDX_W-1:0]     pick_idx;
   logic                 pick_vld;
   logic [7:0]           sel_addr;
   logic [7:0]           sel_data;
   logic                 sel_wen;
   logic                 sel_req;
   int unsigned          cand;

   // Round-robin pick: first set req bit at or above rr_ptr, wrapping.
   always_comb begin
      pick_idx = rr_ptr_q;
      pick_vld = 1'b0;
      cand     = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = 32'(rr_ptr_q) + i;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!pick_vld && bus.req[IDX_W'(cand)]) begin
            pick_vld = 1'b1;
            pick_idx = IDX_W'(cand);
         end
      end
   end

   // Signals of the currently granted requester.
   always_comb begin
      sel_addr = 8'h00;
      sel_data = 8'h00;
      sel_wen  = 1'b0;
      sel_req  = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (IDX_W'(i) == idx_q) begin
            sel_addr = bus.req_addr[8*i +: 8];
            sel_data = bus.req_data[8*i +: 8];
            sel_wen  = bus.req_wen[i];
            sel_req  = bus.req[i];
         end
      end
   end

   assign rr_ptr_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);

   // Arbitration FSM; every output is a register updated here.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         rr_ptr_q <= '0;
         wdog_q   <= '0;
         grant_q  <= '0;
         done_q   <= '0;
         err_q    <= '0;
         addr_q   <= 8'h00;
         data_q   <= 8'h00;
         wen_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         wen_q  <= 1'b0;
         done_q <= '0;
         err_q  <= '0;
         case (state_q)
            S_IDLE: begin
               if (pick_vld) begin
                  idx_q   <= pick_idx;
                  grant_q <= LSB_ONE << pick_idx;
                  state_q <= S_GRANT;
                  busy_q  <= 1'b1;
               end
            end
            S_GRANT: begin
               // A strobe coinciding with req dropping still gets its transfer.
               if (sel_wen) begin
                  addr_q  <= sel_addr;
                  data_q  <= sel_data;
                  wen_q   <= 1'b1;
                  wdog_q  <= '0;
                  state_q <= S_XFER;
               end else if (!sel_req) begin
                  grant_q <= '0;
                  state_q <= S_RELEASE;
               end
            end
            S_XFER: begin
               // done takes priority over a coincident timeout
               if (bus.i2c_done) begin
                  done_q <= grant_q;
                  wdog_q <= '0;
                  if (sel_req) begin
                     state_q <= S_GRANT;
                  end else begin
                     grant_q <= '0;
                     state_q <= S_RELEASE;
                  end
               end else if (wdog_q == TO_LAST) begin
                  err_q   <= grant_q;
                  wdog_q  <= '0;
                  grant_q <= '0;
                  state_q <= S_RELEASE;
               end else begin
                  wdog_q <= wdog_q + TO_WIDTH'(1);
               end
            end
            S_RELEASE: begin
               rr_ptr_q <= rr_ptr_d;
               state_q  <= S_IDLE;
               busy_q   <= 1'b0;
            end
            default: begin
               grant_q <= '0;
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.grant        = grant_q;
   assign bus.req_done     = done_q;
   assign bus.req_err      = err_q;
   assign bus.i2c_reg_addr = addr_q;
   assign bus.i2c_reg_data = data_q;
   assign bus.i2c_write_en = wen_q;
   assign bus.busy         = busy_q;

endmodule

// File: tb/tb_oled_i2c_arbiter.sv
// ---------------------------------------------------------------------------
// tb_oled_i2c_arbiter
//  Directed scenarios followed by randomized multi-requester bursts, checked
//  against a transaction-level round-robin model. A second instance with a
//  short watchdog exercises the timeout path.
// ---------------------------------------------------------------------------
module tb_oled_i2c_arbiter;

   localparam int unsigned N = 3;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   oled_i2c_arbiter_if #(.NUM_REQ(N)) bus ();
   oled_i2c_arbiter_if #(.NUM_REQ(N)) bus_to ();

   oled_i2c_arbiter #(.NUM_REQ(N), .TO_WIDTH(16), .TO_CYCLES(16'd60000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   oled_i2c_arbiter #(.NUM_REQ(N), .TO_WIDTH(16), .TO_CYCLES(16'd16)) dut_to (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_to)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int wen_seen = 0, done_seen = 0, err_seen = 0;
   int exp_wen  = 0, exp_done  = 0;
   logic [7:0] last_addr = 8'h00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [N-1:0] oh(input int i);
      logic [N-1:0] r;
      r    = '0;
      r[i] = 1'b1;
      return r;
   endfunction

   // Reference round-robin choice over the pending requesters.
   function automatic int rr_pick(input logic [N-1:0] p, input int ptr);
      for (int k = 0; k < N; k++) begin
         int c;
         c = (ptr + k) % N;
         if (p[c]) return c;
      end
      return -1;
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Per-cycle invariants and pulse counters.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.i2c_write_en) wen_seen++;
         done_seen += $countones(bus.req_done);
         err_seen  += $countones(bus.req_err);
         chk("onehot", 32'($onehot0(bus.grant)), 32'd1);
         chk("onehot_to", 32'($onehot0(bus_to.grant)), 32'd1);
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
   endtask

   task automatic wait_grant(input int idx, input string tag, output int zeros);
      zeros = 0;
      while (bus.grant === '0 && zeros < 20) begin
         zeros++;
         cyc(1);
      end
      chk(tag, 32'(bus.grant), 32'(oh(idx)));
   endtask

   task automatic wait_idle(input string tag);
      int k;
      k = 0;
      while (bus.busy !== 1'b0 && k < 20) begin
         k++;
         cyc(1);
      end
      chk(tag, 32'(bus.busy), 32'd0);
   endtask

   // One write by the granted requester, optionally dropping req with the
   // strobe and adding a strobe from a non-granted requester.
   task automatic do_write(input int idx, input logic [7:0] a, input logic [7:0] d,
                           input int dly, input bit drop, input bit noise, input string tag);
      int o;
      bus.req_addr[8*idx +: 8] = a;
      bus.req_data[8*idx +: 8] = d;
      bus.req_wen[idx] = 1'b1;
      if (drop) bus.req[idx] = 1'b0;
      if (noise) begin
         o = (idx + 1) % N;
         bus.req_wen[o] = 1'b1;
         bus.req_addr[8*o +: 8] = ~a;
         bus.req_data[8*o +: 8] = ~d;
      end
      cyc(1);
      bus.req_wen = '0;
      chk({tag, ".wen"},  32'(bus.i2c_write_en), 32'd1);
      chk({tag, ".addr"}, 32'(bus.i2c_reg_addr), 32'(a));
      chk({tag, ".data"}, 32'(bus.i2c_reg_data), 32'(d));
      exp_wen++;
      last_addr = a;
      cyc(dly);
      bus.i2c_done = 1'b1;
      cyc(1);
      bus.i2c_done = 1'b0;
      chk({tag, ".done"}, 32'(bus.req_done), 32'(oh(idx)));
      chk({tag, ".err"},  32'(bus.req_err), 32'd0);
      exp_done++;
   endtask

   initial begin
      int zeros;
      int ptr_m;
      int idx;
      logic [N-1:0] pending;
      int lens [N];
      bit first;
      bit dropw;
      logic [N-1:0] err_early;
      logic [N-1:0] done_any;

      bus.req = '0;    bus.req_addr = '0;    bus.req_data = '0;
      bus.req_wen = '0; bus.i2c_done = 1'b0;
      bus_to.req = '0; bus_to.req_addr = '0; bus_to.req_data = '0;
      bus_to.req_wen = '0; bus_to.i2c_done = 1'b0;

      // Reset state
      cyc(2);
      reset = 1'b0;
      cyc(1);
      chk("rst.grant", 32'(bus.grant), 32'd0);
      chk("rst.busy",  32'(bus.busy), 32'd0);
      chk("rst.wen",   32'(bus.i2c_write_en), 32'd0);
      chk("rst.addr",  32'(bus.i2c_reg_addr), 32'd0);
      chk("rst.data",  32'(bus.i2c_reg_data), 32'd0);
      chk("rst.done",  32'(bus.req_done), 32'd0);
      chk("rst.err",   32'(bus.req_err), 32'd0);

      // Single requester, 4-write burst, done 20 cycles after each write_en
      bus.req = 3'b001;
      cyc(1);
      chk("t1.grant_lat", 32'(bus.grant), 32'b001);
      chk("t1.busy", 32'(bus.busy), 32'd1);
      for (int w = 0; w < 4; w++)
         do_write(0, 8'(8'h10 + w), 8'(8'hC0 + 3*w), 20, 1'b0, 1'b0, "t1");
      bus.req[0] = 1'b0;
      cyc(1);
      chk("t1.rel_grant", 32'(bus.grant), 32'd0);
      chk("t1.rel_busy", 32'(bus.busy), 32'd1);
      cyc(1);
      chk("t1.idle_grant", 32'(bus.grant), 32'd0);
      chk("t1.idle_busy", 32'(bus.busy), 32'd0);

      // All three request from rr_ptr = 0: served 0, 1, 2 with gaps
      do_reset();
      bus.req = 3'b111;
      cyc(1);
      chk("t2.g0", 32'(bus.grant), 32'b001);
      do_write(0, 8'h21, 8'h31, 3, 1'b0, 1'b0, "t2.r0");
      bus.req[0] = 1'b0;
      cyc(1);
      wait_grant(1, "t2.g1", zeros);
      chk("t2.gap1", 32'(zeros), 32'd2);
      do_write(1, 8'h22, 8'h32, 2, 1'b0, 1'b0, "t2.r1");
      bus.req[1] = 1'b0;
      cyc(1);
      wait_grant(2, "t2.g2", zeros);
      chk("t2.gap2", 32'(zeros), 32'd2);
      do_write(2, 8'h23, 8'h33, 1, 1'b0, 1'b0, "t2.r2");
      bus.req[2] = 1'b0;
      cyc(1);
      wait_idle("t2.idle");

      // Strobe from a non-granted requester is dropped (rr_ptr = 0)
      bus.req = 3'b010;
      cyc(1);
      chk("t3.grant", 32'(bus.grant), 32'b010);
      bus.req_addr[8*2 +: 8] = 8'hAA;
      bus.req_wen[2] = 1'b1;
      cyc(1);
      bus.req_wen = '0;
      chk("t3.no_wen", 32'(bus.i2c_write_en), 32'd0);
      chk("t3.addr_kept", 32'(bus.i2c_reg_addr), 32'(last_addr));
      chk("t3.grant_kept", 32'(bus.grant), 32'b010);
      cyc(1);
      chk("t3.no_wen2", 32'(bus.i2c_write_en), 32'd0);
      do_write(1, 8'h44, 8'h55, 2, 1'b0, 1'b0, "t3");
      bus.req[1] = 1'b0;
      cyc(1);
      wait_idle("t3.idle");

      // Strobe and req drop together (rr_ptr = 2)
      bus.req = 3'b100;
      cyc(1);
      chk("t5.grant", 32'(bus.grant), 32'b100);
      do_write(2, 8'h66, 8'h77, 4, 1'b1, 1'b0, "t5");
      chk("t5.rel_grant", 32'(bus.grant), 32'd0);
      chk("t5.rel_busy", 32'(bus.busy), 32'd1);
      cyc(1);
      chk("t5.idle_busy", 32'(bus.busy), 32'd0);
      chk("t5.idle_grant", 32'(bus.grant), 32'd0);

      // Watchdog timeout on the short-timeout instance
      bus_to.req = 3'b001;
      cyc(1);
      chk("t4.grant", 32'(bus_to.grant), 32'b001);
      bus_to.req_addr[7:0] = 8'h3C;
      bus_to.req_data[7:0] = 8'hA5;
      bus_to.req_wen[0] = 1'b1;
      cyc(1);
      bus_to.req_wen = '0;
      chk("t4.wen", 32'(bus_to.i2c_write_en), 32'd1);
      err_early = '0;
      done_any  = '0;
      for (int k = 1; k < 16; k++) begin
         cyc(1);
         err_early = err_early | bus_to.req_err;
         done_any  = done_any | bus_to.req_done;
      end
      chk("t4.err_early", 32'(err_early), 32'd0);
      cyc(1);
      done_any = done_any | bus_to.req_done;
      chk("t4.err", 32'(bus_to.req_err), 32'b001);
      chk("t4.grant_drop", 32'(bus_to.grant), 32'd0);
      chk("t4.no_done", 32'(done_any), 32'd0);
      cyc(1);
      chk("t4.err_1cyc", 32'(bus_to.req_err), 32'd0);
      chk("t4.busy0", 32'(bus_to.busy), 32'd0);
      bus_to.req = '0;
      cyc(2);
      chk("t4.idle_grant", 32'(bus_to.grant), 32'd0);
      chk("t4.idle_busy", 32'(bus_to.busy), 32'd0);

      // Reset in the middle of a transfer (rr_ptr = 0)
      bus.req = 3'b001;
      cyc(1);
      chk("t6.grant", 32'(bus.grant), 32'b001);
      bus.req_addr[7:0] = 8'h99;
      bus.req_data[7:0] = 8'h88;
      bus.req_wen[0] = 1'b1;
      cyc(1);
      bus.req_wen = '0;
      chk("t6.wen", 32'(bus.i2c_write_en), 32'd1);
      exp_wen++;
      cyc(5);
      #2 reset = 1'b1;
      #1;
      chk("t6.rst_grant", 32'(bus.grant), 32'd0);
      chk("t6.rst_busy",  32'(bus.busy), 32'd0);
      chk("t6.rst_addr",  32'(bus.i2c_reg_addr), 32'd0);
      chk("t6.rst_data",  32'(bus.i2c_reg_data), 32'd0);
      @(negedge clk);
      bus.req = '0;
      reset = 1'b0;
      cyc(1);
      bus.i2c_done = 1'b1;
      cyc(1);
      bus.i2c_done = 1'b0;
      chk("t6.stray_done", 32'(bus.req_done), 32'd0);
      chk("t6.stray_busy", 32'(bus.busy), 32'd0);
      cyc(1);
      chk("t6.stray_done2", 32'(bus.req_done), 32'd0);

      // Randomized bursts against the round-robin model
      ptr_m = 0;
      for (int r = 0; r < 30; r++) begin
         wait_idle("rnd.idle");
         pending = N'($urandom_range(1, (1 << N) - 1));
         for (int i = 0; i < N; i++) lens[i] = $urandom_range(1, 3);
         bus.req = pending;
         first = 1'b1;
         while (pending != '0) begin
            idx = rr_pick(pending, ptr_m);
            if (first) begin
               cyc(1);
               chk("rnd.grant_lat", 32'(bus.grant), 32'(oh(idx)));
               first = 1'b0;
            end else begin
               wait_grant(idx, "rnd.grant", zeros);
               chk("rnd.gap", 32'(zeros), 32'd2);
            end
            for (int w = 0; w < lens[idx]; w++) begin
               dropw = (w == lens[idx] - 1) && ($urandom_range(0, 1) == 1);
               do_write(idx, 8'($urandom), 8'($urandom), $urandom_range(0, 4),
                        dropw, $urandom_range(0, 1) == 1, "rnd");
            end
            if (!dropw) begin
               bus.req[idx] = 1'b0;
               cyc(1);
            end
            ptr_m = (idx + 1) % N;
            pending[idx] = 1'b0;
         end
      end
      wait_idle("rnd.final_idle");
      cyc(2);

      chk("tot.wen",  32'(wen_seen),  32'(exp_wen));
      chk("tot.done", 32'(done_seen), 32'(exp_done));
      chk("tot.err",  32'(err_seen),  32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Global time bound so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time bound");
      $fatal(1, "time bound expired");
   end

endmodule
